// File: rtl/avl_burst_writer_if.sv
// Avalon-style burst write bus between a burst initiator and an SDRAM
// controller slave port.
//   master: drives address, byte enables, write/read strobes, write data,
//           begin-burst flag, burst count and response-ready; samples wait_request.
//   slave : the mirror image.
interface avl_burst_writer_if;
    logic [31:0] avl_address;
    logic [3:0]  avl_byte_en;
    logic        avl_write;
    logic        avl_read;
    logic [31:0] avl_write_data;
    logic        avl_begin_burst_transfer;
    logic [7:0]  avl_burst_count;
    logic        avl_wait_request;
    logic        avl_resp_ready;

    modport master (
        output avl_address,
        output avl_byte_en,
        output avl_write,
        output avl_read,
        output avl_write_data,
        output avl_begin_burst_transfer,
        output avl_burst_count,
        output avl_resp_ready,
        input  avl_wait_request
    );

    modport slave (
        input  avl_address,
        input  avl_byte_en,
        input  avl_write,
        input  avl_read,
        input  avl_write_data,
        input  avl_begin_burst_transfer,
        input  avl_burst_count,
        input  avl_resp_ready,
        output avl_wait_request
    );
endinterface

// File: rtl/avl_burst_writer.sv
// Burst write initiator: moves a 32-bit word stream into memory as a series
// of Avalon bursts of at most BURST_MAX beats at consecutive byte addresses,
// then pulses done.
//   clk, rest      : clock, synchronous active-high reset
//   cfg_start      : one-cycle start strobe (dropped while a transfer runs)
//   cfg_base_addr  : byte start address (low two bits ignored)
//   cfg_words      : number of words to move
//   busy, done     : transfer in progress / one-cycle completion pulse
//   s_data/s_valid/s_ready : producer stream
//   avl            : Avalon burst master port
module avl_burst_writer #(
    parameter int unsigned BURST_MAX = 64,
    parameter int unsigned LEN_W     = 24
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic                  cfg_start,
    input  logic [31:0]           cfg_base_addr,
    input  logic [LEN_W-1:0]      cfg_words,
    output logic                  busy,
    output logic                  done,
    input  logic [31:0]           s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    avl_burst_writer_if.master    avl
);

    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WADR_W = 30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [WADR_W-1:0]   addr_word;   // next burst start, in 32-bit words
    logic [LEN_W-1:0]    remaining;
    logic [CNT_W-1:0]    beat;
    logic                first;

    logic                in_burst;
    logic                accept;
    logic                last_beat;
    logic [CNT_W-1:0]    burst_len;
    logic                unused_addr_lsb;

    // Byte-lane bits of the base address carry no information.
    assign unused_addr_lsb = ^cfg_base_addr[1:0];

    // Length of the next burst: whatever is left, capped at BURST_MAX.
    assign burst_len = (remaining > LEN_W'(BURST_MAX)) ? CNT_W'(BURST_MAX)
                                                       : CNT_W'(remaining);

    // Stream and bus strobes follow the state directly so a beat can move
    // every cycle; address and count come from registers.
    assign in_burst  = (state == BURST);
    assign accept    = in_burst & s_valid & ~avl.avl_wait_request;
    assign last_beat = (beat == (avl.avl_burst_count - CNT_W'(1)));

    assign avl.avl_write                = in_burst & s_valid;
    assign avl.avl_begin_burst_transfer = in_burst & first & s_valid;
    assign avl.avl_byte_en              = (in_burst & s_valid) ? 4'hF : 4'h0;
    assign avl.avl_write_data           = s_data;
    assign avl.avl_read                 = 1'b0;
    assign avl.avl_resp_ready           = 1'b0;
    assign s_ready                      = in_burst & ~avl.avl_wait_request;

    // Transfer sequencer.
    always_ff @(posedge clk) begin
        if (rest) begin
            state               <= IDLE;
            addr_word           <= '0;
            remaining           <= '0;
            beat                <= '0;
            first               <= 1'b0;
            avl.avl_address     <= '0;
            avl.avl_burst_count <= '0;
            busy                <= 1'b0;
            done                <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        addr_word <= cfg_base_addr[31:2];
                        remaining <= cfg_words;
                        busy      <= 1'b1;
                        if (cfg_words == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ARM;
                        end
                    end
                end
                ARM: begin
                    avl.avl_address     <= {addr_word, 2'b00};
                    avl.avl_burst_count <= burst_len;
                    beat                <= '0;
                    first               <= 1'b1;
                    state               <= BURST;
                end
                BURST: begin
                    if (accept) begin
                        beat      <= beat + CNT_W'(1);
                        remaining <= remaining - LEN_W'(1);
                        first     <= 1'b0;
                        if (last_beat) begin
                            addr_word <= addr_word + WADR_W'(avl.avl_burst_count);
                            // remaining still holds the pre-decrement value here
                            if (remaining == LEN_W'(1)) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state <= ARM;
                            end
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avl_burst_writer.sv
// Scoreboard bench for avl_burst_writer: a producer process drives the stream
// and slave stalls, the driver issues transfers and pushes the expected beats
// and completions, and a monitor pops and compares on every accepted beat
// and every done pulse.
module tb_avl_burst_writer;

    localparam int BM = 64;
    localparam int unsigned LEN_W = 24;

    logic             clk = 1'b0;
    logic             rest;
    logic             cfg_start;
    logic [31:0]      cfg_base_addr;
    logic [LEN_W-1:0] cfg_words;
    logic             busy;
    logic             done;
    logic [31:0]      s_data;
    logic             s_valid;
    logic             s_ready;

    avl_burst_writer_if bus();

    avl_burst_writer #(.BURST_MAX(BM), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rest          (rest),
        .cfg_start     (cfg_start),
        .cfg_base_addr (cfg_base_addr),
        .cfg_words     (cfg_words),
        .busy          (busy),
        .done          (done),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .avl           (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  cnt;
        logic [31:0] data;
        bit          beg;
        bit          first_tx;
    } beat_t;

    beat_t       exp_q[$];
    int          done_q[$];
    logic [31:0] tx_data[$];

    int n_chk = 0;
    int n_pass = 0;
    int start_edge = 0;
    int last_acc = -100;
    int last_wr = -100;
    int acc_total = 0;
    int done_cnt = 0;
    int gen = 0;
    int vmode = 0;
    int wpct = 0;
    bit stall_en = 1'b0;
    bit strict = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Producer: offers words of tx_data, holds a word until it is taken,
    // and drives the slave stall according to the current mode.
    initial begin
        int idx;
        int seen;
        int stall_cnt;
        int tog;
        bit fire;
        bit want;
        idx = 0; seen = 0; stall_cnt = 0; tog = 0;
        s_valid = 1'b0;
        s_data  = '0;
        bus.avl_wait_request = 1'b0;
        forever begin
            @(negedge clk);
            fire = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (gen != seen) begin
                seen = gen; idx = 0; stall_cnt = 0; tog = 0;
                s_valid = 1'b0; fire = 1'b0;
            end else if (fire) begin
                idx++;
            end
            if (!(s_valid && !fire)) begin
                case (vmode)
                    0:       want = 1'b1;
                    1:       want = ((tog % 3) == 0);
                    default: want = ($urandom_range(99) < 70);
                endcase
                s_valid = want && (idx < tx_data.size());
                s_data  = s_valid ? tx_data[idx] : $urandom;
            end
            if (stall_en) begin
                bus.avl_wait_request = (idx == 2) && (stall_cnt < 3);
                if (bus.avl_wait_request) stall_cnt++;
            end else begin
                bus.avl_wait_request = ($urandom_range(99) < wpct);
            end
            tog++;
        end
    end

    // Monitor: compares every accepted beat and every done pulse.
    initial begin
        beat_t e;
        int rc;
        int dl;
        int w;
        bit chk_busy;
        chk_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rest) begin
                chk_busy = 1'b0;
                continue;
            end
            if (chk_busy) begin
                chk("busy_after_done", 32'(busy), 32'd0);
                chk_busy = 1'b0;
            end
            if (bus.avl_write) last_wr = cyc;
            if (bus.avl_write && bus.avl_wait_request)
                chk("ready_during_wait", 32'(s_ready), 32'd0);
            if (bus.avl_write && !bus.avl_wait_request) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_beat: got addr 0x%08h data 0x%08h, expected no beat (cycle %0d)",
                             bus.avl_address, bus.avl_write_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("burst_addr", bus.avl_address, e.addr);
                    chk("burst_count", 32'(bus.avl_burst_count), 32'(e.cnt));
                    chk("write_data", bus.avl_write_data, e.data);
                    chk("begin_burst", 32'(bus.avl_begin_burst_transfer), 32'(e.beg));
                    chk("byte_en", 32'(bus.avl_byte_en), 32'hF);
                    chk("busy_on_beat", 32'(busy), 32'd1);
                    chk("read_tied", 32'({bus.avl_read, bus.avl_resp_ready}), 32'd0);
                    if (e.first_tx) begin rc = start_edge; dl = 1; end
                    else begin rc = last_acc; dl = e.beg ? 2 : 1; end
                    if (strict) chk("beat_timing", 32'(cyc - rc), 32'(dl));
                    else        chk("beat_timing_min", 32'((cyc - rc) >= dl), 32'd1);
                end
                last_acc = cyc;
                acc_total++;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL spurious_done: got done=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    w = done_q.pop_front();
                    if (w == 0) begin
                        chk("zero_done_time", 32'(cyc), 32'(start_edge));
                        chk("zero_no_write", 32'(last_wr < start_edge), 32'd1);
                    end else begin
                        chk("done_time", 32'(cyc), 32'(last_acc + 1));
                        chk("beats_left_at_done", 32'(exp_q.size()), 32'd0);
                    end
                    chk("busy_at_done", 32'(busy), 32'd1);
                end
                done_cnt++;
                chk_busy = 1'b1;
            end
        end
    end

    // Reset for one edge, then check that everything reads zero.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rest = 1'b1;
        exp_q.delete();
        done_q.delete();
        gen++;
        @(posedge clk);
        #1;
        rest = 1'b0;
        @(negedge clk);
        chk("rst_write", 32'(bus.avl_write), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_addr", bus.avl_address, 32'd0);
        chk("rst_count", 32'(bus.avl_burst_count), 32'd0);
        chk("rst_busy_done", 32'({busy, done}), 32'd0);
        chk("rst_begin_be", 32'({bus.avl_begin_burst_transfer, bus.avl_byte_en}), 32'd0);
    endtask

    // Build the expected beat list from the address/length rules and start.
    task automatic start_tx(input logic [31:0] base, input int words,
                            input int vm, input int wp, input bit st);
        beat_t e;
        int b;
        int left;
        tx_data.delete();
        for (int i = 0; i < words; i++) tx_data.push_back($urandom);
        vmode = vm; wpct = wp; stall_en = st;
        strict = (vm == 0) && (wp == 0) && !st;
        for (int i = 0; i < words; i++) begin
            b          = i / BM;
            left       = words - b * BM;
            e.addr     = {base[31:2], 2'b00} + 32'(b * BM * 4);
            e.cnt      = 8'((left < BM) ? left : BM);
            e.data     = tx_data[i];
            e.beg      = ((i % BM) == 0);
            e.first_tx = (i == 0);
            exp_q.push_back(e);
        end
        done_q.push_back(words);
        gen++;
        repeat (2) @(posedge clk);
        #1;
        cfg_base_addr = base;
        cfg_words     = LEN_W'(words);
        cfg_start     = 1'b1;
        start_edge    = cyc + 1;
        @(posedge clk);
        #1;
        cfg_start     = 1'b0;
        cfg_base_addr = $urandom;
        cfg_words     = LEN_W'($urandom);
    endtask

    // Wait (bounded) for the completion pulse; optionally fire a stray start.
    task automatic wait_done(input int d0, input int poke);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            if (n == poke) begin
                cfg_start     = 1'b1;
                cfg_base_addr = $urandom;
                cfg_words     = LEN_W'($urandom_range(1, 300));
            end else begin
                cfg_start = 1'b0;
            end
        end
        cfg_start = 1'b0;
        chk("done_seen", 32'(done_cnt), 32'(d0 + 1));
        if (done_cnt == d0) do_reset();
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic run_tx(input logic [31:0] base, input int words, input int vm,
                          input int wp, input bit st, input int poke);
        int d0;
        d0 = done_cnt;
        start_tx(base, words, vm, wp, st);
        wait_done(d0, poke);
    endtask

    initial begin
        int d0;
        int a0;
        int n;
        rest          = 1'b1;
        cfg_start     = 1'b0;
        cfg_base_addr = '0;
        cfg_words     = '0;
        repeat (3) @(posedge clk);
        do_reset();

        run_tx(32'h0000_0100, 8,   0, 0, 1'b0, 0);   // single burst
        run_tx(32'h0000_0000, 150, 0, 0, 1'b0, 10);  // split + stray start
        run_tx(32'h0000_0040, 8,   0, 0, 1'b1, 0);   // wait stall on beat 2
        run_tx(32'h0000_2000, 70,  1, 0, 1'b0, 0);   // stream gaps
        run_tx(32'h0000_0300, 0,   0, 0, 1'b0, 0);   // zero words

        // Reset in the middle of a burst: no done, then a clean transfer.
        d0 = done_cnt;
        a0 = acc_total;
        start_tx(32'h0000_0800, 20, 0, 0, 1'b0);
        n = 0;
        while (acc_total < a0 + 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("beats_before_reset", 32'(acc_total), 32'(a0 + 3));
        do_reset();
        repeat (6) @(posedge clk);
        chk("no_done_after_reset", 32'(done_cnt), 32'(d0));
        run_tx(32'h0000_0400, 4, 0, 0, 1'b0, 0);

        // Burst-size and address-wrap boundaries.
        run_tx(32'h0000_1000, 64, 0, 0, 1'b0, 0);
        run_tx(32'h0000_3000, 65, 0, 0, 1'b0, 0);
        run_tx(32'h0000_5004, 1,  0, 0, 1'b0, 0);
        run_tx(32'hFFFF_FF03, 70, 0, 0, 1'b0, 0);

        for (int t = 0; t < 8; t++)
            run_tx($urandom, $urandom_range(1, 200), 2, $urandom_range(0, 40), 1'b0, 0);

        chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/avl_burst_writer.md
# avl_burst_writer

Avalon-style burst initiator that moves a 32-bit word stream into SDRAM through the `sdram_controller` slave port. It sits between a pixel/packet producer (valid/ready stream) and the `i_avl_bus` master side. It splits a configured transfer of N words into bursts of at most `BURST_MAX` beats at consecutive byte addresses, then pulses `done`.

## Interface
Parameters:
- `BURST_MAX`, 64: maximum beats per burst; legal range 1..255.
- `LEN_W`, 24: width of the word-count field.

Ports:
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rest`  in  1: reset; synchronous, active-high.
- `cfg_start`  in  1: one-cycle start strobe; ignored while `busy`=1.
- `cfg_base_addr`  in  32: byte start address; bits [1:0] are ignored and treated as 0.
- `cfg_words`  in  LEN_W: number of 32-bit words to write.
- `busy`  out  1: high from the cycle after an accepted start until the cycle `done` is high, inclusive.
- `done`  out  1: one-cycle completion pulse.
- `s_data`  in  32: stream data.
- `s_valid`  in  1: stream valid.
- `s_ready`  out  1: stream ready.
- `avl_address`  out  32: burst start byte address, registered.
- `avl_byte_en`  out  4: 4'hF while `avl_write`=1, else 0.
- `avl_write`  out  1: write request.
- `avl_read`  out  1: tied 0.
- `avl_write_data`  out  32: equals `s_data`.
- `avl_begin_burst_transfer`  out  1: high on the first beat of each burst.
- `avl_burst_count`  out  8: beats in the current burst, registered.
- `avl_wait_request`  in  1: slave stall.
- `avl_resp_ready`  out  1: tied 0.

## Operation
- **States:** IDLE, ARM, BURST, DONE.
- **IDLE:**
  - On `cfg_start`, latch `addr = {cfg_base_addr[31:2], 2'b00}` and `remaining = cfg_words`, then go to ARM.
  - If `cfg_words`=0, go to DONE instead.
- **ARM:**
  - `len = min(remaining, BURST_MAX)`.
  - Load `avl_address = addr`, `avl_burst_count = len`, `beat = 0`, `first = 1`.
  - Go to BURST.
- **BURST:**
  - `avl_write = s_valid`.
  - `s_ready = !avl_wait_request`.
  - `avl_begin_burst_transfer = first & s_valid`.
- **Beat accepted** when `avl_write & !avl_wait_request`. On each accepted beat:
  - `beat++`, `remaining--`, `first = 0`.
  - On the last beat (`beat == len-1`):
    - `addr += len*4` (32-bit wrap allowed, no carry-out handling).
    - Go to DONE if `remaining` becomes 0, else ARM.
- **Stalls and gaps inside a burst:**
  - `avl_address` and `avl_burst_count` stay stable for the whole burst.
  - A stream gap (`s_valid`=0) deasserts `avl_write` without ending the burst.
  - While `avl_wait_request`=1, `s_ready`=0, so `s_data` must be held by the producer; no beat is lost or duplicated.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **Outside BURST:** `avl_write`, `s_ready`, `avl_begin_burst_transfer` and `avl_byte_en` are all 0.
- **Start while busy:** `cfg_start` during ARM, BURST or DONE is dropped.
- **Reset:** `rest`=1 at any point, including mid-burst:
  - Next edge: state IDLE.
  - Registered outputs 0: `avl_address`, `avl_burst_count`, `busy`, `done`.
  - Combinational outputs 0 as state-derived: `avl_write`, `s_ready`.
  - Internal counters cleared.
  - No completion pulse is produced for the aborted transfer.

## Timing
- **Start latency:** start sampled at edge T0 → ARM during cycle T1 → BURST from T2, with the first beat presentable at T2.
- **Inter-burst gap:** one ARM cycle between bursts. Last beat of burst k accepted at edge Tk → first beat of burst k+1 presentable at Tk+2.
- **Completion:** last beat accepted at edge Tl → `done`=1 and `busy`=1 during Tl+1 → `busy`=0 at Tl+2.
- **Zero-length transfer:** `cfg_words`=0 gives `done` in cycle T1 with no Avalon activity.
- **Throughput:** one beat per cycle when `s_valid`=1 and `avl_wait_request`=0.
- **Reset values:** all outputs 0.

## Test plan
- **Single burst:** base 0x100, words 8, `s_valid` constant, no wait → one burst with `avl_address`=0x100 and `burst_count`=8. Eight consecutive beats, data 0..7 in order, `begin_burst_transfer` only on beat 0, `done` at last-accept+1.
- **Split transfer:** base 0, words 150, `BURST_MAX`=64 → bursts (addr, count) of (0x000, 64), (0x100, 64), (0x200, 22). One ARM gap between bursts, 150 beats total, single `done`.
- **Wait stall:** `wait_request` high for 3 cycles on beat 2 → `s_ready`=0 and `write_data` held. Beat 2 is accepted exactly once, and the sequence 0..7 is intact.
- **Stream gaps:** `s_valid` toggled 1,0,0,1,… → `avl_write` follows `s_valid`; `address` and `burst_count` stable; no spurious `begin_burst_transfer` after the first beat.
- **Zero words and ignored start:** words 0 → `done` at T1, `avl_write` never high. A second `cfg_start` mid-transfer is ignored, so burst count and addresses are unchanged.
- **Reset mid-burst:** `rest` at beat 3 → all outputs 0 next edge, no `done`. A new start afterward (base 0x400, words 4) completes normally.
